// File: rtl/cache_ctrl.sv
// cache_ctrl: control FSM for an N-way set-associative cache.
// Keeps tag/valid/dirty state in flops, compares tags on every CPU request,
// picks a victim on a miss (invalid way first, otherwise the PLRU way from
// lru), writes back dirty victims, fetches the missing line and then replays
// the compare so that every request completes through the hit path.
//
// Handshakes: cpu_read/cpu_write act as a request valid that the CPU holds
// until the one-cycle cpu_resp pulse; the request is captured in IDLE and the
// CPU inputs are ignored until cpu_resp. pmem_read/pmem_write are held by this
// block until the one-cycle pmem_resp pulse; pmem_resp is only honoured in
// WRITEBACK and FETCH.
module cache_ctrl #(
   parameter int SETS          = 8,
   parameter int ASSOCIATIVITY = 2,
   parameter int ADDR_W        = 32,
   parameter int LINE_BYTES    = 32,
   parameter int OFF           = $clog2(LINE_BYTES),
   parameter int IDX           = $clog2(SETS),
   parameter int TAG           = ADDR_W - IDX - OFF,
   parameter int W             = $clog2(ASSOCIATIVITY)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_addr,
   input  logic              pmem_resp,
   output logic [IDX-1:0]    data_index,
   output logic [W-1:0]      data_way,
   output logic              data_load_cpu,
   output logic              data_load_mem,
   output logic [IDX-1:0]    lru_index,
   output logic [W-1:0]      lru_mru,
   output logic              lru_load,
   input  logic [W-1:0]      lru_victim,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_COMPARE   = 2'd1,
      S_WRITEBACK = 2'd2,
      S_FETCH     = 2'd3
   } state_t;

   state_t state_q, state_d;

   // Latched request
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [W-1:0]      victim_q;

   // Tag / valid / dirty arrays
   logic [TAG-1:0]           tag_q   [SETS][ASSOCIATIVITY];
   logic [ASSOCIATIVITY-1:0] valid_q [SETS];
   logic [ASSOCIATIVITY-1:0] dirty_q [SETS];

   logic [IDX-1:0] idx;
   logic [TAG-1:0] tag_in;
   logic           req;

   logic           hit;
   logic [W-1:0]   hit_way;
   logic           has_invalid;
   logic [W-1:0]   inv_way;
   logic [W-1:0]   miss_victim;
   logic           victim_dirty;

   assign idx        = addr_q[IDX+OFF-1:OFF];
   assign tag_in     = addr_q[ADDR_W-1:IDX+OFF];
   assign req        = cpu_read | cpu_write;
   assign data_index = idx;
   assign lru_index  = idx;
   assign state_dbg  = state_q;

   // Tag compare across all ways of the latched set
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < ASSOCIATIVITY; w++) begin
         if (valid_q[idx][w] && (tag_q[idx][w] == tag_in)) begin
            hit     = 1'b1;
            hit_way = W'(w);
         end
      end
   end

   // Victim choice: lowest-numbered invalid way, else the PLRU way
   always_comb begin
      has_invalid = 1'b0;
      inv_way     = '0;
      for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
         if (!valid_q[idx][w]) begin
            has_invalid = 1'b1;
            inv_way     = W'(w);
         end
      end
      miss_victim  = has_invalid ? inv_way : lru_victim;
      victim_dirty = valid_q[idx][miss_victim] && dirty_q[idx][miss_victim];
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (req) state_d = S_COMPARE;
         S_COMPARE: begin
            if (hit)               state_d = S_IDLE;
            else if (victim_dirty) state_d = S_WRITEBACK;
            else                   state_d = S_FETCH;
         end
         S_WRITEBACK: if (pmem_resp) state_d = S_FETCH;
         S_FETCH:     if (pmem_resp) state_d = S_COMPARE;
         default:     state_d = S_IDLE;
      endcase
   end

   // Output decode; array-update strobes are suppressed while rst is high
   always_comb begin
      cpu_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr     = {tag_in, idx, {OFF{1'b0}}};
      data_way      = victim_q;
      data_load_cpu = 1'b0;
      data_load_mem = 1'b0;
      lru_mru       = hit_way;
      lru_load      = 1'b0;
      case (state_q)
         S_COMPARE: begin
            data_way = hit ? hit_way : victim_q;
            if (hit && !rst) begin
               cpu_resp      = 1'b1;
               lru_load      = 1'b1;
               data_load_cpu = write_q;
            end
         end
         S_WRITEBACK: begin
            pmem_write = 1'b1;
            pmem_addr  = {tag_q[idx][victim_q], idx, {OFF{1'b0}}};
         end
         S_FETCH: begin
            pmem_read     = 1'b1;
            data_load_mem = pmem_resp && !rst;
         end
         default: ;
      endcase
   end

   // Request latch and victim capture
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q   <= '0;
         write_q  <= 1'b0;
         victim_q <= '0;
      end else begin
         if (state_q == S_IDLE && req) begin
            addr_q  <= cpu_addr;
            write_q <= cpu_write;
         end
         if (state_q == S_COMPARE && !hit) victim_q <= miss_victim;
      end
   end

   // Valid and dirty bit maintenance
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
         end
      end else begin
         case (state_q)
            S_COMPARE: if (hit && write_q) dirty_q[idx][hit_way] <= 1'b1;
            S_WRITEBACK: if (pmem_resp) dirty_q[idx][victim_q] <= 1'b0;
            S_FETCH: begin
               if (pmem_resp) begin
                  valid_q[idx][victim_q] <= 1'b1;
                  dirty_q[idx][victim_q] <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Tag array: contents are meaningless until the valid bit is set
   always_ff @(posedge clk) begin
      if (!rst && state_q == S_FETCH && pmem_resp) tag_q[idx][victim_q] <= tag_in;
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed scenarios for cache_ctrl (8 sets, 4 ways, 32-byte
// lines), each with hand-computed expected values.
module tb_cache_ctrl;

   localparam logic [1:0] ST_IDLE = 2'd0, ST_CMP = 2'd1, ST_WB = 2'd2, ST_FETCH = 2'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_read = 1'b0, cpu_write = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic        cpu_resp;
   logic        pmem_read, pmem_write;
   logic [31:0] pmem_addr;
   logic        pmem_resp = 1'b0;
   logic [2:0]  data_index, lru_index;
   logic [1:0]  data_way, lru_mru, lru_victim = 2'd0;
   logic        data_load_cpu, data_load_mem, lru_load;
   logic [1:0]  state_dbg;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];

   cache_ctrl #(.SETS(8), .ASSOCIATIVITY(4), .ADDR_W(32), .LINE_BYTES(32)) dut (
      .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_addr(cpu_addr), .cpu_resp(cpu_resp), .pmem_read(pmem_read),
      .pmem_write(pmem_write), .pmem_addr(pmem_addr), .pmem_resp(pmem_resp),
      .data_index(data_index), .data_way(data_way), .data_load_cpu(data_load_cpu),
      .data_load_mem(data_load_mem), .lru_index(lru_index), .lru_mru(lru_mru),
      .lru_load(lru_load), .lru_victim(lru_victim), .state_dbg(state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   // Advance one cycle and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a pmem request and report what it was
   task automatic wait_pmem(output logic rd, output logic wr, output logic [31:0] a, output logic ok);
      rd = 1'b0; wr = 1'b0; a = '0; ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (pmem_read || pmem_write) begin
            rd = pmem_read; wr = pmem_write; a = pmem_addr; ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Hold the pmem request for lat cycles, then raise pmem_resp and settle
   task automatic pmem_ack(input int lat);
      repeat (lat) tick();
      pmem_resp = 1'b1;
      #1;
   endtask

   // Drop pmem_resp after the acknowledging edge
   task automatic pmem_done();
      tick();
      pmem_resp = 1'b0;
      #1;
   endtask

   // Wait (bounded) for cpu_resp, capture the strobes, then drop the request
   task automatic wait_cpu_resp(output logic ok, output logic [1:0] mru, output logic [1:0] way,
                                output logic dlc, output logic lld);
      ok = 1'b0; mru = '0; way = '0; dlc = 1'b0; lld = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (cpu_resp) begin
            ok = 1'b1; mru = lru_mru; way = data_way; dlc = data_load_cpu; lld = lru_load;
            cpu_read = 1'b0; cpu_write = 1'b0;
            tick();
            break;
         end
         tick();
      end
      cpu_read = 1'b0; cpu_write = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d exp %0d", state_dbg, ST_IDLE); end
      checks++; if ({cpu_resp, pmem_read, pmem_write, data_load_cpu, data_load_mem, lru_load} !== 6'b0) begin
         failures++; $display("FAIL reset_strobes: got %b exp 000000",
                              {cpu_resp, pmem_read, pmem_write, data_load_cpu, data_load_mem, lru_load}); end
      checks++; if (lru_index !== 3'd0) begin failures++; $display("FAIL reset_addr_q: lru_index got %0d exp 0", lru_index); end
   endtask

   task automatic test_cold_read();
      logic ok; logic [1:0] mru, way; logic dlc, lld;
      cpu_read = 1'b1; cpu_addr = 32'h0000_1040;
      tick();
      checks++; if (state_dbg !== ST_CMP || cpu_resp !== 1'b0 || lru_load !== 1'b0) begin
         failures++; $display("FAIL cold_compare_miss: state %0d resp %b lru_load %b exp 1 0 0", state_dbg, cpu_resp, lru_load); end
      tick();
      checks++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin
         failures++; $display("FAIL cold_fetch_req: read %b write %b exp 1 0", pmem_read, pmem_write); end
      checks++; if (pmem_addr !== 32'h0000_1040) begin failures++; $display("FAIL cold_fetch_addr: got %h exp 00001040", pmem_addr); end
      // The latched request must not follow the CPU address bus
      cpu_addr = 32'hDEAD_BEE0;
      pmem_ack(3);
      checks++; if (pmem_addr !== 32'h0000_1040) begin failures++; $display("FAIL cold_addr_latched: got %h exp 00001040", pmem_addr); end
      checks++; if (data_load_mem !== 1'b1 || data_way !== 2'd0) begin
         failures++; $display("FAIL cold_load_mem: load %b way %0d exp 1 0", data_load_mem, data_way); end
      pmem_done();
      checks++; if (cpu_resp !== 1'b1 || lru_load !== 1'b1 || lru_mru !== 2'd0 || lru_index !== 3'd2 || data_index !== 3'd2) begin
         failures++; $display("FAIL cold_resp: resp %b lru_load %b mru %0d lru_idx %0d data_idx %0d exp 1 1 0 2 2",
                              cpu_resp, lru_load, lru_mru, lru_index, data_index); end
      wait_cpu_resp(ok, mru, way, dlc, lld);
      cpu_addr = '0;
      checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL cold_back_idle: got %0d exp 0", state_dbg); end
   endtask

   task automatic test_hit_latency();
      cpu_read = 1'b1; cpu_addr = 32'h0000_1044;
      #1;
      checks++; if (cpu_resp !== 1'b0) begin failures++; $display("FAIL hit_early_resp: got %b exp 0", cpu_resp); end
      tick();
      checks++; if (cpu_resp !== 1'b1 || lru_mru !== 2'd0 || pmem_read !== 1'b0 || pmem_write !== 1'b0 || data_load_cpu !== 1'b0) begin
         failures++; $display("FAIL hit_resp: resp %b mru %0d pr %b pw %b dlc %b exp 1 0 0 0 0",
                              cpu_resp, lru_mru, pmem_read, pmem_write, data_load_cpu); end
      cpu_read = 1'b0;
      tick();
   endtask

   task automatic test_fill_and_write();
      logic ok, rd, wr, dlc, lld; logic [31:0] a; logic [1:0] mru, way;
      for (int i = 1; i < 4; i++) begin
         cpu_read = 1'b1; cpu_addr = 32'h0000_0040 | (32'(i + 1) << 12);
         wait_pmem(rd, wr, a, ok);
         checks++; if (!ok || rd !== 1'b1 || wr !== 1'b0 || a !== cpu_addr) begin
            failures++; $display("FAIL fill_fetch_%0d: ok %b rd %b wr %b addr %h exp 1 1 0 %h", i, ok, rd, wr, a, cpu_addr); end
         pmem_ack(2);
         checks++; if (data_load_mem !== 1'b1 || data_way !== 2'(i)) begin
            failures++; $display("FAIL fill_way_%0d: load %b way %0d exp 1 %0d", i, data_load_mem, data_way, i); end
         pmem_done();
         wait_cpu_resp(ok, mru, way, dlc, lld);
         checks++; if (!ok || mru !== 2'(i) || lld !== 1'b1) begin
            failures++; $display("FAIL fill_resp_%0d: ok %b mru %0d lru_load %b exp 1 %0d 1", i, ok, mru, lld, i); end
      end
      cpu_write = 1'b1; cpu_addr = 32'h0000_2040;
      tick();
      checks++; if (cpu_resp !== 1'b1 || data_load_cpu !== 1'b1 || data_way !== 2'd1 || lru_mru !== 2'd1) begin
         failures++; $display("FAIL write_hit: resp %b dlc %b way %0d mru %0d exp 1 1 1 1", cpu_resp, data_load_cpu, data_way, lru_mru); end
      cpu_write = 1'b0;
      tick();
   endtask

   task automatic test_writeback();
      logic ok, rd, wr, dlc, lld; logic [31:0] a, e; logic [1:0] mru, way;
      lru_victim = 2'd1;
      exp_q.push_back(32'h0000_2040);
      exp_q.push_back(32'h0000_5040);
      cpu_read = 1'b1; cpu_addr = 32'h0000_5040;
      wait_pmem(rd, wr, a, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || wr !== 1'b1 || rd !== 1'b0 || a !== e || data_way !== 2'd1) begin
         failures++; $display("FAIL wb_req: ok %b wr %b rd %b addr %h way %0d exp 1 1 0 %h 1", ok, wr, rd, a, data_way, e); end
      pmem_ack(1);
      pmem_done();
      wait_pmem(rd, wr, a, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || rd !== 1'b1 || wr !== 1'b0 || a !== e) begin
         failures++; $display("FAIL wb_fetch: ok %b rd %b wr %b addr %h exp 1 1 0 %h", ok, rd, wr, a, e); end
      pmem_ack(2);
      checks++; if (data_load_mem !== 1'b1 || data_way !== 2'd1) begin
         failures++; $display("FAIL wb_load: load %b way %0d exp 1 1", data_load_mem, data_way); end
      pmem_done();
      wait_cpu_resp(ok, mru, way, dlc, lld);
      checks++; if (!ok || mru !== 2'd1) begin failures++; $display("FAIL wb_resp: ok %b mru %0d exp 1 1", ok, mru); end
      // Way 1 now holds tag 0x50: a re-read hits
      cpu_read = 1'b1; cpu_addr = 32'h0000_5044;
      tick();
      checks++; if (cpu_resp !== 1'b1 || lru_mru !== 2'd1 || pmem_read !== 1'b0) begin
         failures++; $display("FAIL wb_rehit: resp %b mru %0d pr %b exp 1 1 0", cpu_resp, lru_mru, pmem_read); end
      cpu_read = 1'b0;
      tick();
      // Way 1 is clean: evicting it again goes straight to a fetch
      cpu_read = 1'b1; cpu_addr = 32'h0000_6040;
      wait_pmem(rd, wr, a, ok);
      checks++; if (!ok || rd !== 1'b1 || wr !== 1'b0 || a !== 32'h0000_6040) begin
         failures++; $display("FAIL clean_evict: ok %b rd %b wr %b addr %h exp 1 1 0 00006040", ok, rd, wr, a); end
      pmem_ack(1);
      pmem_done();
      wait_cpu_resp(ok, mru, way, dlc, lld);
      checks++; if (!ok || mru !== 2'd1) begin failures++; $display("FAIL clean_evict_resp: ok %b mru %0d exp 1 1", ok, mru); end
   endtask

   task automatic test_read_write_both();
      logic ok, rd, wr, dlc, lld; logic [31:0] a; logic [1:0] mru, way;
      cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 32'h0000_3048;
      tick();
      checks++; if (cpu_resp !== 1'b1 || data_load_cpu !== 1'b1 || data_way !== 2'd2) begin
         failures++; $display("FAIL rw_as_write: resp %b dlc %b way %0d exp 1 1 2", cpu_resp, data_load_cpu, data_way); end
      cpu_read = 1'b0; cpu_write = 1'b0;
      tick();
      // The dirty bit shows up as a writeback when way 2 is evicted
      lru_victim = 2'd2;
      cpu_read = 1'b1; cpu_addr = 32'h0000_7040;
      wait_pmem(rd, wr, a, ok);
      checks++; if (!ok || wr !== 1'b1 || a !== 32'h0000_3040) begin
         failures++; $display("FAIL rw_dirty_wb: ok %b wr %b addr %h exp 1 1 00003040", ok, wr, a); end
      pmem_ack(1);
      pmem_done();
      wait_pmem(rd, wr, a, ok);
      pmem_ack(1);
      pmem_done();
      wait_cpu_resp(ok, mru, way, dlc, lld);
      checks++; if (!ok || mru !== 2'd2) begin failures++; $display("FAIL rw_evict_resp: ok %b mru %0d exp 1 2", ok, mru); end
   endtask

   task automatic test_pmem_resp_idle();
      pmem_resp = 1'b1;
      #1;
      checks++; if (data_load_mem !== 1'b0) begin failures++; $display("FAIL idle_resp_load: got %b exp 0", data_load_mem); end
      tick();
      pmem_resp = 1'b0;
      #1;
      checks++; if (state_dbg !== ST_IDLE || cpu_resp !== 1'b0) begin
         failures++; $display("FAIL idle_resp_ignored: state %0d resp %b exp 0 0", state_dbg, cpu_resp); end
   endtask

   task automatic test_reset_mid_fetch();
      logic ok, rd, wr, dlc, lld; logic [31:0] a; logic [1:0] mru, way;
      lru_victim = 2'd0;
      cpu_read = 1'b1; cpu_addr = 32'h0000_8040;
      wait_pmem(rd, wr, a, ok);
      checks++; if (!ok || rd !== 1'b1 || a !== 32'h0000_8040 || state_dbg !== ST_FETCH) begin
         failures++; $display("FAIL rst_pre_fetch: ok %b rd %b addr %h state %0d exp 1 1 00008040 3", ok, rd, a, state_dbg); end
      rst = 1'b1; pmem_resp = 1'b1;
      #1;
      checks++; if (data_load_mem !== 1'b0) begin failures++; $display("FAIL rst_no_load: got %b exp 0", data_load_mem); end
      tick();
      rst = 1'b0; pmem_resp = 1'b0; cpu_read = 1'b0;
      #1;
      checks++; if (state_dbg !== ST_IDLE || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
         failures++; $display("FAIL rst_to_idle: state %0d pr %b pw %b exp 0 0 0", state_dbg, pmem_read, pmem_write); end
      tick();
      // Valid bits were cleared: a previously resident line misses
      cpu_read = 1'b1; cpu_addr = 32'h0000_1040;
      tick();
      checks++; if (cpu_resp !== 1'b0) begin failures++; $display("FAIL rst_reread_miss: resp got %b exp 0", cpu_resp); end
      tick();
      checks++; if (pmem_read !== 1'b1 || pmem_addr !== 32'h0000_1040) begin
         failures++; $display("FAIL rst_reread_fetch: pr %b addr %h exp 1 00001040", pmem_read, pmem_addr); end
      pmem_ack(1);
      pmem_done();
      wait_cpu_resp(ok, mru, way, dlc, lld);
      checks++; if (!ok || mru !== 2'd0) begin failures++; $display("FAIL rst_reread_resp: ok %b mru %0d exp 1 0", ok, mru); end
   endtask

   initial begin
      test_reset();
      test_cold_read();
      test_hit_latency();
      test_fill_and_write();
      test_writeback();
      test_read_write_both();
      test_pmem_resp_idle();
      test_reset_mid_fetch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
